// File: rtl/cnn_pkg.sv
// Shared constants for the 3x3 window fetch path: pixel width, window geometry
// and the fetch FSM state encoding.
package cnn_pkg;

    localparam int CNN_DATA_W = 16;
    localparam int WIN_DIM    = 3;
    localparam int WIN_SIZE   = WIN_DIM * WIN_DIM;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Valid (unpadded) 3x3 windows in a w x h frame.
    function automatic int win_total(input int w, input int h);
        return (w - 2) * (h - 2);
    endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// One-row delay line: a DEPTH-entry RAM with registered read. The caller
// presents the address of the next column to be consumed so read data is ready.
module cnn_line_buffer #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/conv_window_fetch.sv
// Streams a frame from image RAM in raster order and presents every unpadded
// 3x3 window on a valid/ready port, with a one-pixel skid for stalled returns.
module conv_window_fetch
    import cnn_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int DATA_W = CNN_DATA_W,
    parameter int ADDR_W = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          img_base,
    output logic                       busy,
    output logic                       done,
    output logic                       mem_rd_en,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [WIN_SIZE*DATA_W-1:0] win_data,
    output logic [ADDR_W-1:0]          win_row,
    output logic [ADDR_W-1:0]          win_col
);

    localparam int CW        = $clog2(IMG_W);
    localparam int RW        = $clog2(IMG_H);
    localparam int WIN_TOTAL = win_total(IMG_W, IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t                      state_reg, state_next;
    logic [ADDR_W-1:0]           addr_reg;
    logic [RW-1:0]               rd_row_reg;
    logic [CW-1:0]               rd_col_reg;
    logic [RW-1:0]               px_row_reg;
    logic [CW-1:0]               px_col_reg;
    logic                        rvalid_reg;
    logic                        hold_valid_reg;
    logic [DATA_W-1:0]           hold_data_reg;
    logic                        win_valid_reg;
    logic [WIN_SIZE*DATA_W-1:0]  win_data_reg;
    logic [ADDR_W-1:0]           win_row_reg;
    logic [ADDR_W-1:0]           win_col_reg;
    logic [31:0]                 win_cnt_reg;

    logic                        stalled;
    logic                        hshake;
    logic                        rd_issue;
    logic                        last_read;
    logic                        last_win;
    logic                        completes;
    logic                        use_hold;
    logic                        park;
    logic                        accept;
    logic                        emit;
    logic [DATA_W-1:0]           pix;
    logic [CW-1:0]               px_col_next;
    logic [CW-1:0]               lb_rd_addr;
    logic [DATA_W-1:0]           lb0_q;
    logic [DATA_W-1:0]           lb1_q;
    logic [DATA_W-1:0]           col_in [WIN_DIM];
    logic [WIN_SIZE*DATA_W-1:0]  win_next;

    assign stalled   = win_valid_reg && !win_ready;
    assign hshake    = win_valid_reg && win_ready;
    assign rd_issue  = (state_reg == ST_FETCH) && !stalled && !hold_valid_reg;
    assign last_read = rd_issue && (rd_row_reg == ROW_LAST) && (rd_col_reg == COL_LAST);
    assign last_win  = hshake && (win_cnt_reg == 32'(WIN_TOTAL - 1));

    // Only window-completing pixels need the output register, so only they park.
    assign completes = (px_row_reg >= RW'(2)) && (px_col_reg >= CW'(2));
    assign use_hold  = hold_valid_reg && !stalled;
    assign park      = rvalid_reg && completes && stalled;
    assign accept    = use_hold || (rvalid_reg && !park);
    assign emit      = accept && completes;
    assign pix       = use_hold ? hold_data_reg : mem_rdata;

    assign px_col_next = (px_col_reg == COL_LAST) ? '0 : px_col_reg + CW'(1);
    assign lb_rd_addr  = accept ? px_col_next : px_col_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_FETCH;
            ST_FETCH: if (last_read) state_next = ST_DRAIN;
            ST_DRAIN: if (last_win) state_next = ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            rd_row_reg  <= '0;
            rd_col_reg  <= '0;
            px_row_reg  <= '0;
            px_col_reg  <= '0;
            rvalid_reg  <= 1'b0;
            win_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            rvalid_reg <= rd_issue;
            if (state_reg == ST_IDLE && start) begin
                addr_reg    <= img_base;
                rd_row_reg  <= '0;
                rd_col_reg  <= '0;
                px_row_reg  <= '0;
                px_col_reg  <= '0;
                win_cnt_reg <= '0;
            end else begin
                if (rd_issue) begin
                    addr_reg <= addr_reg + ADDR_W'(1);
                    if (rd_col_reg == COL_LAST) begin
                        rd_col_reg <= '0;
                        rd_row_reg <= rd_row_reg + RW'(1);
                    end else begin
                        rd_col_reg <= rd_col_reg + CW'(1);
                    end
                end
                if (accept) begin
                    px_col_reg <= px_col_next;
                    if (px_col_reg == COL_LAST) begin
                        px_row_reg <= px_row_reg + RW'(1);
                    end
                end
                if (hshake) begin
                    win_cnt_reg <= win_cnt_reg + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
        end else if (park) begin
            hold_valid_reg <= 1'b1;
            hold_data_reg  <= mem_rdata;
        end else if (use_hold) begin
            hold_valid_reg <= 1'b0;
        end
    end

    cnn_line_buffer #(
        .DEPTH  (IMG_W),
        .DATA_W (DATA_W)
    ) u_lb0 (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (px_col_reg),
        .wr_data (pix),
        .rd_addr (lb_rd_addr),
        .rd_data (lb0_q)
    );

    cnn_line_buffer #(
        .DEPTH  (IMG_W),
        .DATA_W (DATA_W)
    ) u_lb1 (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (px_col_reg),
        .wr_data (lb0_q),
        .rd_addr (lb_rd_addr),
        .rd_data (lb1_q)
    );

    // Row 0 is two lines up, row 2 is the pixel arriving now.
    assign col_in[0] = lb1_q;
    assign col_in[1] = lb0_q;
    assign col_in[2] = pix;

    // Each row keeps its two previous columns; the third comes straight from col_in.
    generate
        for (genvar gi = 0; gi < WIN_DIM; gi++) begin : g_row
            logic [DATA_W-1:0] tap_old_reg;
            logic [DATA_W-1:0] tap_new_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tap_old_reg <= '0;
                    tap_new_reg <= '0;
                end else if (accept) begin
                    tap_old_reg <= tap_new_reg;
                    tap_new_reg <= col_in[gi];
                end
            end

            assign win_next[(3*gi+0)*DATA_W +: DATA_W] = tap_old_reg;
            assign win_next[(3*gi+1)*DATA_W +: DATA_W] = tap_new_reg;
            assign win_next[(3*gi+2)*DATA_W +: DATA_W] = col_in[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid_reg <= 1'b0;
            win_data_reg  <= '0;
            win_row_reg   <= '0;
            win_col_reg   <= '0;
        end else if (emit) begin
            win_valid_reg <= 1'b1;
            win_data_reg  <= win_next;
            win_row_reg   <= ADDR_W'(px_row_reg - RW'(2));
            win_col_reg   <= ADDR_W'(px_col_reg - CW'(2));
        end else if (hshake) begin
            win_valid_reg <= 1'b0;
        end
    end

    assign busy      = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);
    assign done      = (state_reg == ST_DONE);
    assign mem_rd_en = rd_issue;
    assign mem_addr  = addr_reg;
    assign win_valid = win_valid_reg;
    assign win_data  = win_data_reg;
    assign win_row   = win_row_reg;
    assign win_col   = win_col_reg;

endmodule

// File: tb/tb_conv_window_fetch.sv
// Scoreboard bench: a 4x4 instance for directed frames and a 32x32 instance
// fed a ramp image under random backpressure.
module tb_conv_window_fetch;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int WL = 32;
    localparam int HL = 32;
    localparam int DW = 16;
    localparam int AW = 20;

    typedef struct {
        logic [9*DW-1:0] d;
        logic [AW-1:0]   r;
        logic [AW-1:0]   c;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            start;
    logic [AW-1:0]   img_base;
    logic            busy, done, mem_rd_en, win_valid, win_ready;
    logic [AW-1:0]   mem_addr, win_row, win_col;
    logic [DW-1:0]   mem_rdata;
    logic [9*DW-1:0] win_data;
    logic [AW-1:0]   mem_base;

    logic            l_start;
    logic [AW-1:0]   l_base;
    logic            l_busy, l_done, l_mem_rd_en, l_win_valid, l_win_ready;
    logic [AW-1:0]   l_mem_addr, l_win_row, l_win_col;
    logic [DW-1:0]   l_mem_rdata;
    logic [9*DW-1:0] l_win_data;

    conv_window_fetch #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .img_base(img_base),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .win_valid(win_valid), .win_ready(win_ready),
        .win_data(win_data), .win_row(win_row), .win_col(win_col)
    );

    conv_window_fetch #(.IMG_W(WL), .IMG_H(HL), .DATA_W(DW), .ADDR_W(AW)) dut_l (
        .clk(clk), .rst(rst), .start(l_start), .img_base(l_base),
        .busy(l_busy), .done(l_done), .mem_rd_en(l_mem_rd_en), .mem_addr(l_mem_addr),
        .mem_rdata(l_mem_rdata), .win_valid(l_win_valid), .win_ready(l_win_ready),
        .win_data(l_win_data), .win_row(l_win_row), .win_col(l_win_col)
    );

    // Image RAMs: pixel value = word offset from the frame base.
    always @(posedge clk) begin
        mem_rdata   <= mem_rd_en ? DW'(mem_addr - mem_base) : 16'hDEAD;
        l_mem_rdata <= l_mem_rd_en ? DW'(l_mem_addr - l_base) : 16'hDEAD;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9*DW-1:0] exp_win(input int r, input int c, input int w);
        logic [9*DW-1:0] e;
        e = '0;
        for (int k = 0; k < 9; k++) begin
            e[k*DW +: DW] = DW'((r + k / 3) * w + c + k % 3);
        end
        return e;
    endfunction

    exp_t sb[$];
    exp_t sb_l[$];
    int hs_cnt, done_cnt, rd_cnt, last_hs_cyc, done_cyc;
    logic [AW-1:0] first_addr, last_addr;
    int l_hs_cnt, l_done_cnt;

    // Monitors: pop an expected window on every handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (win_valid && win_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_window", {win_row, win_col}, '1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("win_data", win_data, e.d);
                    chk("win_pos", {win_row, win_col}, {e.r, e.c});
                end
                hs_cnt++;
                last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (mem_rd_en) begin
                if (rd_cnt == 0) first_addr = mem_addr;
                last_addr = mem_addr;
                rd_cnt++;
            end
            if (l_win_valid && l_win_ready) begin
                if (sb_l.size() == 0) begin
                    chk("l_unexpected_window", {l_win_row, l_win_col}, '1);
                end else begin
                    exp_t e;
                    e = sb_l.pop_front();
                    chk("l_window", {l_win_row, l_win_col, l_win_data}, {e.r, e.c, e.d});
                end
                l_hs_cnt++;
            end
            if (l_done) l_done_cnt++;
        end
    end

    task automatic run_frame(input logic [AW-1:0] base, input bit stall, input bit restart);
        int n;
        int rd_stall;
        int held_bad;
        sb.delete();
        hs_cnt = 0; done_cnt = 0; rd_cnt = 0; rd_stall = 0; held_bad = 0;
        for (int r = 0; r < H - 2; r++)
            for (int c = 0; c < W - 2; c++)
                sb.push_back('{exp_win(r, c, W), AW'(r), AW'(c)});
        mem_base  = base;
        win_ready = !stall;
        start     = 1'b1;
        img_base  = base;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        if (restart) begin
            repeat (3) @(posedge clk);
            #1;
            start    = 1'b1;
            img_base = base + AW'(7);
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (stall) begin
            n = 0;
            while (!win_valid && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            chk("first_valid_seen", win_valid, 1'b1);
            repeat (20) begin
                @(negedge clk);
                if (mem_rd_en) rd_stall++;
                if (win_data !== exp_win(0, 0, W) || !win_valid) held_bad++;
                @(posedge clk); #1;
            end
            chk("stall_rd_en_low", rd_stall, 0);
            chk("stall_window_held", held_bad, 0);
            win_ready = 1'b1;
        end
        n = 0;
        while (done_cnt == 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt, 1);
        chk("window_count", hs_cnt, (W - 2) * (H - 2));
        chk("scoreboard_empty", sb.size(), 0);
        chk("done_after_last_hs", done_cyc, last_hs_cyc + 1);
        chk("read_count", rd_cnt, W * H);
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; img_base = '0; mem_base = '0; win_ready = 1'b1;
        l_start = 1'b0; l_base = '0; l_win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd_en", mem_rd_en, 1'b0);
        chk("rst_valid", win_valid, 1'b0);
        chk("rst_addr", mem_addr, '0);
        chk("rst_data", win_data, '0);
        chk("rst_pos", {win_row, win_col}, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 4x4 ramp, always ready
        run_frame(20'h0, 1'b0, 1'b0);
        chk("base0_first_addr", first_addr, 20'h0);
        chk("base0_last_addr", last_addr, 20'hF);

        // backpressure right after the first window
        run_frame(20'h0, 1'b1, 1'b0);

        // offset base
        run_frame(20'h100, 1'b0, 1'b0);
        chk("base100_first_addr", first_addr, 20'h100);
        chk("base100_last_addr", last_addr, 20'h10F);

        // second start while busy must be ignored
        run_frame(20'h0, 1'b0, 1'b1);

        // reset mid-fetch, then a clean frame
        mem_base = '0; img_base = 20'h40; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midframe_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_rd_en", mem_rd_en, 1'b0);
        chk("async_rst_addr", mem_addr, '0);
        chk("async_rst_valid", win_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_frame(20'h0, 1'b0, 1'b0);

        // 32x32 ramp under random backpressure
        sb_l.delete();
        l_hs_cnt = 0; l_done_cnt = 0;
        for (int r = 0; r < HL - 2; r++)
            for (int c = 0; c < WL - 2; c++)
                sb_l.push_back('{exp_win(r, c, WL), AW'(r), AW'(c)});
        l_start = 1'b1;
        @(posedge clk); #1;
        l_start = 1'b0;
        n = 0;
        while (l_done_cnt == 0 && n < 20000) begin
            l_win_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        l_win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("l_done_seen", l_done_cnt, 1);
        chk("l_window_count", l_hs_cnt, 900);
        chk("l_scoreboard_empty", sb_l.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
